i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//   I2C target (slave) responder: the other end of our i2c_main bus master.
//   Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
//   Decodes the 7-bit address and R/W bit, ACKs its own address, and delivers written
//   bytes on rx_*. Serves read bytes from tx_* with a fetch handshake.
//   Drives SDA open-drain only. Never drives or stretches SCL.
// PARAMETERS
//   ADDR      7'h50   7-bit target address this block answers to
// PORTS
//   clk       in   1  system clock, >= 8x SCL frequency
//   reset     in   1  reset, synchronous, active-high
//   scl_i     in   1  raw SCL pin level (asynchronous)
//   sda_i     in   1  raw SDA pin level (asynchronous)
//   sda_oe    out  1  1 = pull SDA low; 0 = release SDA (pad is open-drain)
//   rx_data   out  8  last byte written by the master, MSB first on the wire
//   rx_valid  out  1  one-clk pulse; rx_data is valid in that cycle
//   tx_data   in   8  byte to send on a read; sampled on the tx_req pulse
//   tx_req    out  1  one-clk pulse requesting the next read byte
//   busy      out  1  1 from an address match until STOP, or until NACK/mismatch ends the transfer
// BEHAVIOUR
//   - Input path: 2-FF synchronizer per pin, then a 1-FF edge detector.
//     Edges are seen 3 clk after the pin changes. Synchronizers reset to 1.
//   - Reset values: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, state IDLE.
//     Reset mid-transfer releases SDA on the next clk.
//   - START/Sr = SDA fall while SCL high. Goes to ADDR from ANY state;
//     clears the bit count and drops any partial byte.
//   - STOP = SDA rise while SCL high. Goes to IDLE from ANY state; sda_oe=0, busy=0.
//     A partial byte gives no rx_valid.
//   - SDA is sampled on synchronized SCL rise. sda_oe changes only on synchronized SCL fall.
//   - Bit counter is 3 bits and counts 7..0. Shift register is 8 bits, MSB first.
//   - States and transitions:
//       IDLE     : START -> ADDR
//       ADDR     : after 8 bits {addr[6:0],rw}:
//                    addr==ADDR -> ADDR_ACK, busy=1
//                    otherwise  -> WAIT_STOP, SDA never driven
//       ADDR_ACK : sda_oe=1 from the SCL fall after bit 8 to the SCL fall after bit 9.
//                  rw=0 -> WR_DATA. rw=1 -> tx_req pulse on the SCL rise of bit 9, then RD_DATA.
//       WR_DATA  : after 8 bits: rx_data<=shift, rx_valid pulse (same clk), -> WR_ACK
//       WR_ACK   : drive ACK (sda_oe=1) for the 9th clock, as in ADDR_ACK; -> WR_DATA
//       RD_DATA  : tx_data latched on the tx_req clk.
//                  Bit 7 is driven from the SCL fall that ends the ACK (sda_oe = ~bit).
//                  Shift on each SCL fall. After 8 bits, release SDA -> RD_ACK.
//       RD_ACK   : sample master on the SCL rise of bit 9:
//                    SDA=0 (ACK)  -> tx_req pulse, RD_DATA
//                    SDA=1 (NACK) -> WAIT_STOP, busy=0
//       WAIT_STOP: SDA released; ignore bits; wait for START/STOP
//   - SDA changes while SCL is high that are neither START nor STOP cannot occur
//     after synchronization. No error flag.
//   - Simultaneous STOP and SCL edge in one clk: STOP wins.
//   - General call (addr 0) and 10-bit addressing are not supported; treated as mismatch.
// STRUCTURE
//   - i2c_pkg: enum i2c_tgt_state_t {IDLE,ADDR,ADDR_ACK,WR_DATA,WR_ACK,RD_DATA,RD_ACK,WAIT_STOP};
//     localparams I2C_ACK=1'b0, I2C_NACK=1'b1.
//   - Sub-module i2c_sync_edge: 2-FF synchronizer + rise/fall pulses,
//     outputs {lvl, rise, fall}. Instantiated once per pin.
//   - Top level: FSM, bit counter, shift register, output registers.
// TESTING  (bench models the master with SCL = clk/16, open-drain wired-AND on SDA)
//   1. START, 0x50+W, data 0xAA, STOP
//      -> sda_oe=1 in both 9th clocks; one rx_valid with rx_data=8'hAA; busy 1->0 after STOP
//   2. START, 0x51+W, 0xAA, STOP
//      -> sda_oe stays 0 throughout; no rx_valid; busy stays 0; state IDLE after STOP
//   3. START, 0x50+R; tx_data=8'h3C then 8'hC3; master ACK then NACK
//      -> SDA carries 00111100 then 11000011; exactly 2 tx_req pulses; SDA released after NACK
//   4. Write 0x50, 4 bits of data, then Sr, 0x50+W, 0x5A, STOP
//      -> partial byte discarded; one rx_valid with 8'h5A; ACK given after the Sr address
//   5. Reset asserted while sda_oe=1 during a read bit
//      -> next clk: sda_oe=0, busy=0, state IDLE; the next START is accepted normally
//   6. STOP after 5 data bits of a write
//      -> no rx_valid; IDLE; a following full write of 0x11 gives rx_data=8'h11

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target block.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_tgt_state_t;

  // Level of SDA during the 9th clock: low acknowledges, high refuses.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit counter start value; bytes go MSB first, so the count runs 7..0.
  localparam logic [2:0] I2C_BIT_FIRST = 3'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes one asynchronous bus pin and flags its rising/falling edges.
// Latency: level and edge pulses appear 3 clk after the pin changes.
// Backpressure: none; free-running, one pulse per observed edge.
module i2c_sync_edge
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic lvl_q;
  logic rise_q;
  logic fall_q;

  // Two-flop synchronizer, then a delayed copy to compare against for edges.
  // Everything idles high so releasing reset on an idle bus yields no edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      lvl_q  <= sync_q;
      rise_q <= sync_q & ~lvl_q;
      fall_q <= ~sync_q & lvl_q;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address decode, ACK generation, write delivery and read serving.
// Latency: bus events act 4 clk after the pin edge; rx_valid on the 8th SCL rise.
// Backpressure: none; tx_data must be valid on the tx_req pulse, SCL is never stretched.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  import i2c_pkg::*;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (scl_i),
    .lvl_o  (scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (sda_i),
    .lvl_o  (sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // Both pins share the same pipeline depth, so SCL level and SDA edges line up.
  logic start_det;
  logic stop_det;
  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;

  i2c_tgt_state_t state_q;
  logic [2:0]     cnt_q;
  logic [7:0]     shift_q;
  logic           rw_q;
  logic           last_q;
  logic           sda_oe_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;
  logic           tx_req_q;
  logic           busy_q;

  // Shift register contents after taking the bit sampled on this SCL rise.
  logic [7:0] shift_in;
  assign shift_in = {shift_q[6:0], sda_lvl};

  // Protocol FSM with bit counter, shift register and registered outputs.
  // STOP outranks START, which outranks any SCL edge in the same clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= I2C_BIT_FIRST;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      last_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q  <= i2c_pkg::ADDR;
        cnt_q    <= I2C_BIT_FIRST;
        shift_q  <= 8'h00;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          i2c_pkg::ADDR: begin
            if (scl_rise) begin
              shift_q <= shift_in;
              cnt_q   <= cnt_q - 3'd1;
              if (cnt_q == 3'd0) begin
                if (shift_in[7:1] == ADDR) begin
                  rw_q    <= shift_in[0];
                  busy_q  <= 1'b1;
                  state_q <= ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            // First fall starts the ACK; a read leaves on the 9th rise so the
            // next fall can hand SDA straight over to data bit 7.
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= I2C_BIT_FIRST;
                state_q  <= WR_DATA;
              end
            end else if (scl_rise && sda_oe_q && rw_q) begin
              tx_req_q <= 1'b1;
              cnt_q    <= I2C_BIT_FIRST;
              last_q   <= 1'b0;
              state_q  <= RD_DATA;
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift_q <= shift_in;
              cnt_q   <= cnt_q - 3'd1;
              if (cnt_q == 3'd0) begin
                rx_data_q  <= shift_in;
                rx_valid_q <= 1'b1;
                state_q    <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q <= 1'b0;
                cnt_q    <= I2C_BIT_FIRST;
                state_q  <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            // last_q marks that bit 0 has been clocked; the following fall
            // releases SDA so the master can answer.
            if (tx_req_q) begin
              shift_q <= tx_data;
            end else if (scl_fall) begin
              if (last_q) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sda_oe_q <= ~shift_q[7];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end else if (scl_rise) begin
              cnt_q <= cnt_q - 3'd1;
              if (cnt_q == 3'd0) begin
                last_q <= 1'b1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == I2C_ACK) begin
                tx_req_q <= 1'b1;
                cnt_q    <= I2C_BIT_FIRST;
                last_q   <= 1'b0;
                state_q  <= RD_DATA;
              end else begin
                busy_q  <= 1'b0;
                state_q <= WAIT_STOP;
              end
            end
          end
          default: begin
            // IDLE and WAIT_STOP only react to START/STOP.
          end
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bus master model with open-drain SDA.
// Latency: bit period is 16 clk; outputs sampled on the falling clk edge.
// Backpressure: none; write data is scoreboarded through queues.
module tb_i2c_target;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic [7:0] tx_data;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  wire        sda_line = sda_m & ~sda_oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_wr[$];
  logic [7:0] rx_obs[$];
  logic [7:0] exp_rd[$];
  int tx_cnt   = 0;
  int oe_cnt   = 0;
  int busy_cnt = 0;

  i2c_target #(.ADDR(7'h50)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Output monitor: collects delivered bytes and counts activity.
  always @(negedge clk) begin
    if (rx_valid) rx_obs.push_back(rx_data);
    if (tx_req)   tx_cnt = tx_cnt + 1;
    if (sda_oe)   oe_cnt = oe_cnt + 1;
    if (busy)     busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic line_s, output logic oe_s);
    sda_m = b;
    wclk(4);
    scl = 1'b1;
    wclk(4);
    line_s = sda_line;
    oe_s   = sda_oe;
    wclk(4);
    scl = 1'b0;
    wclk(4);
  endtask

  task automatic start_c();
    sda_m = 1'b1;
    wclk(4);
    scl = 1'b1;
    wclk(4);
    sda_m = 1'b0;
    wclk(4);
    scl = 1'b0;
    wclk(4);
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    wclk(4);
    scl = 1'b1;
    wclk(4);
    sda_m = 1'b1;
    wclk(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic ack_oe);
    logic l, o;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], l, o);
    clock_bit(1'b1, ack, ack_oe);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b, output logic oe9);
    logic l, o;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, l, o);
      b[i] = l;
    end
    clock_bit(mack, l, oe9);
  endtask

  task automatic drain_rx(input string tag);
    chk({tag, "_cnt"}, rx_obs.size(), exp_wr.size());
    while (rx_obs.size() > 0 && exp_wr.size() > 0)
      chk({tag, "_data"}, rx_obs.pop_front(), exp_wr.pop_front());
    rx_obs.delete();
    exp_wr.delete();
  endtask

  initial begin
    logic       ack, aoe, l, o;
    logic [7:0] rb;
    int         t0, oe0, b0;

    reset = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    wclk(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dut.state_q, IDLE);
    reset = 1'b0;
    wclk(4);

    // 1: matched write of 0xAA
    start_c();
    send_byte(8'hA0, ack, aoe);
    chk("t1_addr_ack", ack, I2C_ACK);
    chk("t1_addr_oe", aoe, 1);
    chk("t1_busy", busy, 1);
    exp_wr.push_back(8'hAA);
    send_byte(8'hAA, ack, aoe);
    chk("t1_data_ack", ack, I2C_ACK);
    chk("t1_data_oe", aoe, 1);
    stop_c();
    wclk(4);
    drain_rx("t1_rx");
    chk("t1_busy_end", busy, 0);
    chk("t1_state", dut.state_q, IDLE);

    // 2: foreign address is ignored
    oe0 = oe_cnt; b0 = busy_cnt;
    start_c();
    send_byte(8'hA2, ack, aoe);
    chk("t2_addr_nack", ack, I2C_NACK);
    send_byte(8'hAA, ack, aoe);
    chk("t2_data_nack", ack, I2C_NACK);
    stop_c();
    wclk(4);
    chk("t2_oe_never", oe_cnt - oe0, 0);
    chk("t2_busy_never", busy_cnt - b0, 0);
    drain_rx("t2_rx");
    chk("t2_state", dut.state_q, IDLE);

    // 3: read 0x3C (master ACK) then 0xC3 (master NACK)
    t0 = tx_cnt;
    tx_data = 8'h3C;
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'hC3);
    start_c();
    send_byte(8'hA1, ack, aoe);
    chk("t3_addr_ack", ack, I2C_ACK);
    tx_data = 8'hC3;
    recv_byte(I2C_ACK, rb, o);
    chk("t3_byte0", rb, exp_rd.pop_front());
    chk("t3_byte0_rel", o, 0);
    recv_byte(I2C_NACK, rb, o);
    chk("t3_byte1", rb, exp_rd.pop_front());
    chk("t3_byte1_rel", o, 0);
    wclk(2);
    chk("t3_tx_req_cnt", tx_cnt - t0, 2);
    chk("t3_sda_rel", sda_oe, 0);
    chk("t3_busy_nack", busy, 0);
    chk("t3_state", dut.state_q, WAIT_STOP);
    stop_c();
    wclk(4);
    chk("t3_state_end", dut.state_q, IDLE);

    // 4: partial byte then repeated START and a full write
    start_c();
    send_byte(8'hA0, ack, aoe);
    chk("t4_addr_ack", ack, I2C_ACK);
    clock_bit(1'b1, l, o);
    clock_bit(1'b0, l, o);
    clock_bit(1'b1, l, o);
    clock_bit(1'b1, l, o);
    start_c();
    send_byte(8'hA0, ack, aoe);
    chk("t4_sr_ack", ack, I2C_ACK);
    chk("t4_sr_oe", aoe, 1);
    exp_wr.push_back(8'h5A);
    send_byte(8'h5A, ack, aoe);
    chk("t4_data_ack", ack, I2C_ACK);
    stop_c();
    wclk(4);
    drain_rx("t4_rx");

    // 5: reset while driving a read bit
    tx_data = 8'h00;
    start_c();
    send_byte(8'hA1, ack, aoe);
    chk("t5_addr_ack", ack, I2C_ACK);
    clock_bit(1'b1, l, o);
    chk("t5_bit7_line", l, 0);
    clock_bit(1'b1, l, o);
    sda_m = 1'b1;
    wclk(4);
    scl = 1'b1;
    wclk(2);
    chk("t5_pre_oe", sda_oe, 1);
    reset = 1'b1;
    wclk(1);
    chk("t5_rst_oe", sda_oe, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_state", dut.state_q, IDLE);
    reset = 1'b0;
    wclk(4);
    scl = 1'b0;
    wclk(4);
    start_c();
    send_byte(8'hA0, ack, aoe);
    chk("t5_again_ack", ack, I2C_ACK);
    exp_wr.push_back(8'h77);
    send_byte(8'h77, ack, aoe);
    stop_c();
    wclk(4);
    drain_rx("t5_rx");

    // 6: STOP after 5 data bits, then a clean write of 0x11
    start_c();
    send_byte(8'hA0, ack, aoe);
    chk("t6_addr_ack", ack, I2C_ACK);
    for (int i = 0; i < 5; i++) clock_bit(i[0], l, o);
    stop_c();
    wclk(4);
    chk("t6_state", dut.state_q, IDLE);
    chk("t6_busy", busy, 0);
    drain_rx("t6_partial");
    start_c();
    send_byte(8'hA0, ack, aoe);
    exp_wr.push_back(8'h11);
    send_byte(8'h11, ack, aoe);
    chk("t6_data_ack", ack, I2C_ACK);
    stop_c();
    wclk(4);
    drain_rx("t6_rx");
    chk("t6_rx_data", rx_data, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
